// File: rtl/clock_pkg.sv
// Shared clock definitions: BCD time word layout, field limits and helpers
// used by the time keeper, alarm and display logic.
package clock_pkg;

  localparam int unsigned HOUR_T_LSB = 18;
  localparam int unsigned HOUR_U_LSB = 14;
  localparam int unsigned MIN_T_LSB  = 11;
  localparam int unsigned MIN_U_LSB  = 7;
  localparam int unsigned SEC_T_LSB  = 4;
  localparam int unsigned SEC_U_LSB  = 0;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  typedef struct packed {
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } time_t;

  function automatic int unsigned bcd_value(input logic [3:0] tens, input logic [3:0] units);
    return 32'(tens) * 10 + 32'(units);
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Edit/time bundle between the time keeper and its user (buttons, display).
interface time_keeper_if import clock_pkg::*; ();
  logic [1:0] edit_btns;
  time_t      current_time;
  logic       second_tick;

  modport master (output edit_btns, input current_time, input second_tick);
  modport slave  (input edit_btns, output current_time, output second_tick);
endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..CLK_FREQ-1 and flags the last count; restart forces 0.
module tick_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(CLK_FREQ - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (restart || tick) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD clock: advances once per prescaler tick, with minute/hour edit
// pulses that take priority over (and discard) a coincident tick.
module time_keeper import clock_pkg::*; #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  time_keeper_if.slave tk
);

  logic  tick;
  logic  restart;
  time_t time_q, time_d;
  logic  second_tick_q, second_tick_d;

  assign restart = |tk.edit_btns;

  tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  function automatic time_t inc_min(input time_t t);
    time_t r = t;
    if (bcd_value({1'b0, t.min_t}, t.min_u) == MIN_MAX) begin
      r.min_t = '0;
      r.min_u = '0;
    end else if (t.min_u == 4'd9) begin
      r.min_t = t.min_t + 3'd1;
      r.min_u = '0;
    end else begin
      r.min_u = t.min_u + 4'd1;
    end
    return r;
  endfunction

  function automatic time_t inc_hour(input time_t t);
    time_t r = t;
    if (bcd_value({2'b00, t.hour_t}, t.hour_u) == HOUR_MAX) begin
      r.hour_t = '0;
      r.hour_u = '0;
    end else if (t.hour_u == 4'd9) begin
      r.hour_t = t.hour_t + 2'd1;
      r.hour_u = '0;
    end else begin
      r.hour_u = t.hour_u + 4'd1;
    end
    return r;
  endfunction

  // Whole next time word is built here, so every carry lands in one edge.
  always_comb begin
    time_d        = time_q;
    second_tick_d = 1'b0;
    if (restart) begin
      if (tk.edit_btns[0]) begin
        time_d       = inc_min(time_d);
        time_d.sec_t = '0;
        time_d.sec_u = '0;
      end
      if (tk.edit_btns[1]) time_d = inc_hour(time_d);
    end else if (tick) begin
      second_tick_d = 1'b1;
      if (bcd_value({1'b0, time_q.sec_t}, time_q.sec_u) == SEC_MAX) begin
        time_d.sec_t = '0;
        time_d.sec_u = '0;
        if (bcd_value({1'b0, time_q.min_t}, time_q.min_u) == MIN_MAX)
          time_d = inc_hour(time_d);
        time_d = inc_min(time_d);
      end else if (time_q.sec_u == 4'd9) begin
        time_d.sec_t = time_q.sec_t + 3'd1;
        time_d.sec_u = '0;
      end else begin
        time_d.sec_u = time_q.sec_u + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_q        <= '0;
      second_tick_q <= 1'b0;
    end else begin
      time_q        <= time_d;
      second_tick_q <= second_tick_d;
    end
  end

  assign tk.current_time = time_q;
  assign tk.second_tick  = second_tick_q;

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clk cycles per second (minimum 2).
REQ-002 clk  in  1  system clock; all state on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 edit_btns  in  2  single-cycle increment pulses; [1] = hours, [0] = minutes.
REQ-005 current_time  out  20  BCD time, laid out below.
- [19:18] hour tens (0-2)
- [17:14] hour units
- [13:11] minute tens (0-5)
- [10:7] minute units
- [6:4] second tens (0-5)
- [3:0] second units
REQ-006 second_tick  out  1  one-cycle pulse in the cycle the seconds field advances.

Function
REQ-007 Prescaler SHALL count 0..CLK_FREQ-1 and wrap; tick SHALL be asserted internally when the count equals CLK_FREQ-1.
REQ-008 On tick with no edit pulse, time SHALL advance by one second in BCD on the next clk edge:
- seconds 59 -> 00 with carry to minutes;
- minutes 59 -> 00 with carry to hours;
- hours 23 -> 00.
REQ-009 Every field SHALL hold only valid BCD digits within its range; no intermediate non-BCD value SHALL ever appear on current_time.
REQ-010 A minute pulse (edit_btns[0]) SHALL set minutes to (minutes+1) mod 60 and seconds to 00, with no carry into hours.
REQ-011 An hour pulse (edit_btns[1]) SHALL set hours to (hours+1) mod 24; minutes and seconds are unaffected unless REQ-010 applies in the same cycle.
REQ-012 When both edit bits are 1 in the same cycle, both REQ-010 and REQ-011 SHALL be applied in that cycle.
REQ-013 Any edit pulse SHALL reset the prescaler to 0; a tick coinciding with an edit SHALL be discarded, and second_tick SHALL stay 0 in that cycle.
REQ-014 Latency: current_time SHALL reflect a tick or edit on the clk edge that samples it (one cycle), and SHALL be driven directly from registers.
REQ-015 second_tick SHALL be registered and high for exactly the one cycle in which current_time shows the new second.
REQ-016 An edit_btns level held high for N cycles SHALL produce N increments; the block performs no edge detection.

Reset
REQ-017 While reset = 0, current_time SHALL be 20'h00000 (00:00:00), second_tick SHALL be 0 and the prescaler SHALL be 0, asynchronously.
REQ-018 After reset deasserts, the first tick SHALL occur CLK_FREQ cycles later.
REQ-019 Reset asserted mid-count or mid-edit SHALL discard the pending tick or edit.

Structure
REQ-020 Shared package clock_pkg SHALL hold the field bit-position constants, the per-field maximum constants (23, 59, 59), and a packed struct type for the 20-bit time word; the same type is used by the alarm and display logic.
REQ-021 The prescaler SHALL be one sub-module, tick_gen, parameterised by CLK_FREQ, with inputs clk, reset and restart, and output tick.
REQ-022 All BCD increment and carry logic SHALL reside in time_keeper.

Verification (CLK_FREQ = 4)
REQ-023 Reset, then 4 cycles idle -> current_time = 20'h00001 and second_tick high for exactly 1 cycle.
REQ-024 Preload 23:59:59 via edits and ticks, then one tick -> current_time = 00:00:00 with all fields rolled over in a single cycle.
REQ-025 At 10:59:30, one minute pulse -> 10:00:00 (hours unchanged); then one hour pulse at 23:xx -> 00:xx.
REQ-026 Both edit bits pulsed in the same cycle as a tick at 05:07:12 -> 06:08:00, second_tick = 0, next tick 4 cycles later.
REQ-027 reset driven low asynchronously between clk edges at 12:34:56 -> current_time = 00:00:00 immediately, before the next clk edge.
REQ-028 edit_btns[0] held high for 3 cycles at 00:58:00 -> 00:01:00; free-run check that every field stays in BCD range over 90000 ticks.
